sync_filter: RTL and testbench
==============================

Name: sync_filter

Overview:
- Multi-channel clock-domain input synchroniser with a per-channel glitch filter and edge-pulse outputs.
- Sits at asynchronous inputs such as pads, straps, interrupt lines and slow status flags from other clock domains.
- Delivers a clean, debounced level plus single-cycle rise/fall strobes in the clk_i domain.
- Generalises the single-bit two-flop synchroniser in three ways: channel count, programmable depth, and a filtering mode.

Parameters:
- Width, 4: number of independent channels (>=1).
- Stages, 2: synchroniser flop depth per channel (>=2).
- FilterCycles, 3: consecutive cycles a new synchronised value must persist before the output accepts it (>=1; 1 = no filtering).
- ResetValue, '0 (Width bits): per-channel reset/clear value of all synchroniser flops and of serial_o.

Ports:
- clk_i  in  1  sole clock.
- rst_i  in  1  synchronous, active-high reset.
- clr_i  in  1  synchronous clear; same effect as rst_i.
- serial_i  in  Width  asynchronous inputs.
- serial_o  out  Width  synchronised, filtered level.
- rise_o  out  Width  one-cycle pulse on a 0->1 change of serial_o.
- fall_o  out  Width  one-cycle pulse on a 1->0 change of serial_o.

Behaviour:
- Single clock domain; reset is synchronous and active-high. Clock and reset ports are clk_i and rst_i.
- Reset/clear: on any edge with rst_i or clr_i high, the block loads:
  - every synchroniser stage of channel k with ResetValue[k];
  - serial_o = ResetValue;
  - all filter counters = 0;
  - rise_o = fall_o = 0.
  - rst_i and clr_i are ORed; there is no priority difference.
- Synchroniser: per channel, a shift chain s[0..Stages-1] with s[0] <= serial_i[k]. The synchronised value is sync_k = s[Stages-1]. No logic is allowed between stages.
- Filter, per channel, counter cnt of width $clog2(FilterCycles), minimum 1 bit:
  - if sync_k == serial_o[k]: cnt <= 0;
  - else if cnt == FilterCycles-1: serial_o[k] <= sync_k and cnt <= 0;
  - else: cnt <= cnt+1.
- Latency: a change on serial_i that is stable and captured at edge E appears on serial_o at edge E+Stages+FilterCycles-1. Example: Stages=2, FilterCycles=3 gives serial_o updating 4 edges after capture.
- Glitch rejection: a synchronised pulse shorter than FilterCycles cycles never reaches serial_o. A pulse of exactly FilterCycles cycles passes.
- Edge strobes are registered in the same edge that updates serial_o:
  - rise_o[k] = 1 for exactly the first cycle serial_o[k] reads 1 after having read 0;
  - fall_o[k] behaves the same way for 1->0;
  - rise_o and fall_o are never both high on one channel.
- Channels are fully independent. Simultaneous changes on several channels update them in the same cycle.
- Reset mid-operation:
  - counters are discarded and no rise/fall pulse is produced by the reset itself, even if serial_o changes value;
  - filtering restarts from ResetValue after deassertion.
- FilterCycles=1: the counter is unused, and serial_o follows sync_k with one extra register stage.
- All outputs come directly from flops; there are no combinational input-to-output paths.

Decomposition:
- Package sync_filter_pkg holds:
  - function cnt_width(int unsigned) returning max(1, $clog2(FilterCycles));
  - parameter sanity checks (Stages>=2, FilterCycles>=1, Width>=1) as elaboration assertions.
- Sub-module sync_filter_chan: one channel comprising the sync chain, counter, output flop and edge flops. The top level generates Width instances.

Test Plan:
- Reset: Width=4, ResetValue=4'b0101, drive serial_i=4'b1010 during rst_i for 3 cycles. Required: serial_o=4'b0101 and rise_o=fall_o=0 throughout. After release, serial_o becomes 4'b1010 exactly Stages+FilterCycles cycles later, with rise_o=4'b1010 and fall_o=4'b0101 pulsing for one cycle.
- Step: Stages=2, FilterCycles=3, serial_i[0] 0->1 captured at edge 10 and held. Required: serial_o[0]=1 from edge 14, rise_o[0] high only in cycle 14, other channels unchanged.
- Glitch: a 2-cycle high on serial_i[1] gives no change on serial_o[1] and no pulses. A 3-cycle high gives rise_o[1] and, 3 cycles later, fall_o[1], each as a single pulse.
- Simultaneous: all 4 channels toggle on the same edge. Required: all serial_o bits update in the same cycle, with correct rise/fall pattern per bit.
- Clear mid-filter: assert clr_i for 1 cycle while cnt=1 on channel 2. Required: no pulse, serial_o[2]=ResetValue[2], full Stages+FilterCycles latency restarts.
- FilterCycles=1, Stages=3: input step gives serial_o change 3 edges after capture, with a single rise_o pulse.

Source files
------------

// File: rtl/sync_filter_pkg.sv
// Shared helpers for the multi-channel synchroniser / glitch filter.
package sync_filter_pkg;

    // Filter counter width: enough to reach FilterCycles-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned filter_cycles);
        return (filter_cycles <= 2) ? 32'd1 : 32'($clog2(filter_cycles));
    endfunction

    // Legal parameter combination: at least one channel, two sync stages, one filter cycle.
    function automatic bit params_ok(input int unsigned width,
                                     input int unsigned stages,
                                     input int unsigned filter_cycles);
        return (width >= 1) && (stages >= 2) && (filter_cycles >= 1);
    endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One channel: synchroniser chain, persistence filter, level flop and edge strobes.
module sync_filter_chan
    import sync_filter_pkg::*;
#(
    parameter int unsigned Stages       = 2,
    parameter int unsigned FilterCycles = 3,
    parameter logic        ResetBit     = 1'b0
) (
    input  logic clk_i,
    input  logic clear_i,
    input  logic serial_i,
    output logic serial_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned      CntW   = cnt_width(FilterCycles);
    localparam logic [CntW-1:0]  CntMax = CntW'(FilterCycles - 1);

    logic [Stages-1:0] sync_q;
    logic              sync;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              out_q, out_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    // Plain shift chain into the clock domain; nothing sits between stages.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            sync_q <= {Stages{ResetBit}};
        end else begin
            sync_q <= {sync_q[Stages-2:0], serial_i};
        end
    end

    assign sync = sync_q[Stages-1];

    // Accept a new level only after it has disagreed with the output for FilterCycles edges.
    // With FilterCycles=1 CntMax is zero, so the output simply follows sync one edge later.
    always_comb begin
        out_d = out_q;
        cnt_d = cnt_q;
        if (sync == out_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            out_d = sync;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
        rise_d = out_d & ~out_q;
        fall_d = ~out_d & out_q;
    end

    // Filter state and strobes; clear never produces a strobe even if the level jumps.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            cnt_q  <= '0;
            out_q  <= ResetBit;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign serial_o = out_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/sync_filter.sv
// Multi-channel input synchroniser with glitch filter and rise/fall strobes.
module sync_filter
    import sync_filter_pkg::*;
#(
    parameter int unsigned     Width        = 4,
    parameter int unsigned     Stages       = 2,
    parameter int unsigned     FilterCycles = 3,
    parameter logic [Width-1:0] ResetValue  = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic [Width-1:0] serial_i,
    output logic [Width-1:0] serial_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o
);

    if (!params_ok(Width, Stages, FilterCycles)) begin : g_bad_params
        $error("sync_filter: need Width>=1, Stages>=2, FilterCycles>=1");
    end

    // Reset and clear are interchangeable.
    logic clear;
    assign clear = rst_i | clr_i;

    for (genvar k = 0; k < Width; k++) begin : g_chan
        sync_filter_chan #(
            .Stages       (Stages),
            .FilterCycles (FilterCycles),
            .ResetBit     (ResetValue[k])
        ) u_chan (
            .clk_i    (clk_i),
            .clear_i  (clear),
            .serial_i (serial_i[k]),
            .serial_o (serial_o[k]),
            .rise_o   (rise_o[k]),
            .fall_o   (fall_o[k])
        );
    end

endmodule

// File: tb/tb_sync_filter.sv
// Scoreboard bench: two configurations share stimulus; a reference model predicts every cycle.
module tb_sync_filter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [3:0] serial = 4'b1010;

    logic [3:0] so0, ro0, fo0;
    logic [3:0] so1, ro1, fo1;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // Config 0: Stages=2, FilterCycles=3, ResetValue=0101
    sync_filter #(.Width(4), .Stages(2), .FilterCycles(3), .ResetValue(4'b0101)) dut0 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .serial_i(serial),
        .serial_o(so0), .rise_o(ro0), .fall_o(fo0));

    // Config 1: Stages=3, FilterCycles=1, ResetValue=0
    sync_filter #(.Width(4), .Stages(3), .FilterCycles(1), .ResetValue(4'b0000)) dut1 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .serial_i(serial),
        .serial_o(so1), .rise_o(ro1), .fall_o(fo1));

    // ---------------- reference model ----------------
    int unsigned ST [2] = '{2, 3};
    int unsigned FC [2] = '{3, 1};
    logic [3:0]  RV [2] = '{4'b0101, 4'b0000};

    // hist: value entering the sync chain at each edge (reset loads the whole chain)
    bit          hist   [2][4][$];
    bit          lvl    [2][4];
    int          disagree [2][4];
    logic [11:0] expq   [2][$];
    bit          started = 1'b0;

    initial begin
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++) begin
                for (int s = 0; s < int'(ST[d]); s++) hist[d][k].push_back(RV[d][k]);
                lvl[d][k] = RV[d][k];
                disagree[d][k] = 0;
            end
    end

    always @(posedge clk) begin
        logic [3:0] e_lvl, e_rise, e_fall;
        bit sync, old;
        if (rst || clr) started = 1'b1;
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 4; k++) begin
                    e_rise[k] = 1'b0;
                    e_fall[k] = 1'b0;
                    if (rst || clr) begin
                        for (int s = 0; s < int'(ST[d]); s++) hist[d][k].push_back(RV[d][k]);
                        lvl[d][k] = RV[d][k];
                        disagree[d][k] = 0;
                    end else begin
                        // value visible at the end of the chain = what entered ST edges ago
                        sync = hist[d][k][hist[d][k].size() - ST[d]];
                        hist[d][k].push_back(serial[k]);
                        old = lvl[d][k];
                        if (sync == old) disagree[d][k] = 0;
                        else disagree[d][k]++;
                        if (disagree[d][k] >= int'(FC[d])) begin
                            lvl[d][k] = sync;
                            disagree[d][k] = 0;
                            e_rise[k] = sync & ~old;
                            e_fall[k] = ~sync & old;
                        end
                    end
                    while (hist[d][k].size() > 8) void'(hist[d][k].pop_front());
                    e_lvl[k] = lvl[d][k];
                end
                expq[d].push_back({e_lvl, e_rise, e_fall});
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [11:0] exp_v, act_v;
        for (int d = 0; d < 2; d++) begin
            if (expq[d].size() > 0) begin
                exp_v = expq[d].pop_front();
                act_v = (d == 0) ? {so0, ro0, fo0} : {so1, ro1, fo1};
                tests++;
                if (act_v !== exp_v) begin
                    failed++;
                    $display("FAIL cfg%0d t=%0t serial/rise/fall got %b/%b/%b want %b/%b/%b",
                             d, $time, act_v[11:8], act_v[7:4], act_v[3:0],
                             exp_v[11:8], exp_v[7:4], exp_v[3:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [3:0] s, input logic r, input logic c, input int n);
        serial = s;
        rst    = r;
        clr    = c;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [3:0] v;
        @(negedge clk);
        // reset held with opposite pattern on the inputs
        step(4'b1010, 1'b1, 1'b0, 3);
        // reset release: 1010 propagates, rise on 1010, fall on 0101
        step(4'b1010, 1'b0, 1'b0, 10);
        // single-channel step on channel 0
        step(4'b1011, 1'b0, 1'b0, 10);
        // glitch on channel 1: 2 cycles (rejected), then 3 cycles (passes)
        step(4'b1001, 1'b0, 1'b0, 2);
        step(4'b1011, 1'b0, 1'b0, 8);
        step(4'b1001, 1'b0, 1'b0, 3);
        step(4'b1011, 1'b0, 1'b0, 10);
        // all channels toggle together
        step(4'b0100, 1'b0, 1'b0, 10);
        step(4'b1011, 1'b0, 1'b0, 10);
        // clear mid-filter on channel 2 (counter at 1 in config 0)
        step(4'b1111, 1'b0, 1'b0, 3);
        step(4'b1111, 1'b0, 1'b1, 1);
        step(4'b1111, 1'b0, 1'b0, 10);
        // randomized phase: varied hold lengths, occasional clear or reset
        for (int i = 0; i < 300; i++) begin
            v = 4'($urandom_range(0, 15));
            step(v, ($urandom_range(0, 59) == 0), ($urandom_range(0, 39) == 0),
                 $urandom_range(1, 5));
        end
        step(serial, 1'b0, 1'b0, 8);
        #1;
        tests++;
        if (expq[0].size() != 0 || expq[1].size() != 0) begin
            failed++;
            $display("FAIL drain queue sizes got %0d/%0d want 0/0", expq[0].size(), expq[1].size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
